// File: rtl/trace_logger_mc.sv
// Trace logger: buffers tracer words into a single-port trace memory on write turns and
// serves tracer loads on read turns, in circular trace-buffer or streaming FIFO mode.
module trace_logger_mc #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 256,
    parameter int DELAY_BITS = 3,
    parameter int CNT_BITS   = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic                  MODE_I,
    input  logic [DELAY_BITS-1:0] DELAY_I,
    input  logic                  ARM_I,
    input  logic                  RW_TURN_I,
    input  logic                  WRITE_ALLOW_I,
    input  logic                  READ_ALLOW_I,
    output logic                  WRITE_O,
    output logic [AW-1:0]         WRITE_PTR_O,
    output logic [AW-1:0]         READ_PTR_O,
    output logic [WIDTH-1:0]      DMEM_O,
    input  logic [WIDTH-1:0]      DMEM_I,
    input  logic                  STORE_I,
    input  logic [WIDTH-1:0]      DATA_I,
    output logic                  STORE_PERM_O,
    input  logic                  LOAD_REQUEST_I,
    output logic                  LOAD_GRANT_O,
    output logic [WIDTH-1:0]      DATA_O,
    input  logic                  TRG_EVENT_I,
    output logic                  TRG_DELAYED_O,
    output logic [AW-1:0]         EVENT_ADDR_O,
    output logic [AW:0]           FILL_O,
    output logic [CNT_BITS-1:0]   DROP_CNT_O,
    output logic [CNT_BITS-1:0]   OVWR_CNT_O
);

    typedef enum logic [1:0] {IDLE, COUNTING, DONE} trgState_e;

    localparam int HW = AW + DELAY_BITS + 1;
    localparam logic [HW-1:0] DEPTH_M1 = HW'(DEPTH - 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

    trgState_e             state_q, state_d;
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW-1:0]         eventAddr_q, eventAddr_d, hist_q, hist_d;
    logic [AW:0]           count_q, count_d;
    logic                  mode_q, mode_d, pendW_q, pendW_d, pendR_q, pendR_d;
    logic                  grant_q, grant_d;
    logic [WIDTH-1:0]      dmem_q, dmem_d, data_q, data_d;
    logic [CNT_BITS-1:0]   drop_q, drop_d, ovwr_q, ovwr_d;

    logic                  full, wrOk, wc, rc, storePerm;
    logic [HW-1:0]         histProd;

    // Post-trigger quota is a fraction (DELAY_I+1)/2^DELAY_BITS of the buffer.
    assign histProd  = (HW'(DELAY_I) + HW'(1)) * DEPTH_M1;

    assign full      = (count_q == FULL);
    assign wrOk      = mode_q ? !full : (state_q != DONE);
    assign wc        = RW_TURN_I & WRITE_ALLOW_I & pendW_q & wrOk;
    assign rc        = !RW_TURN_I & READ_ALLOW_I & pendR_q & (count_q != '0)
                       & (mode_q | (state_q == DONE));
    assign storePerm = !pendW_q | wc;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        eventAddr_d = eventAddr_q;
        hist_d      = hist_q;
        count_d     = count_q;
        mode_d      = mode_q;
        pendW_d     = pendW_q;
        pendR_d     = pendR_q;
        grant_d     = 1'b0;
        dmem_d      = dmem_q;
        data_d      = data_q;
        drop_d      = drop_q;
        ovwr_d      = ovwr_q;
        if (ARM_I) begin
            state_d     = IDLE;
            wptr_d      = '0;
            rptr_d      = '0;
            eventAddr_d = '0;
            hist_d      = '0;
            count_d     = '0;
            mode_d      = MODE_I;
            pendW_d     = 1'b0;
            pendR_d     = 1'b0;
            drop_d      = '0;
            ovwr_d      = '0;
        end else begin
            if (wc) begin
                wptr_d  = wptr_q + AW'(1);
                pendW_d = 1'b0;
                // A full trace buffer discards its oldest word to make room.
                if (!mode_q && full) begin
                    rptr_d = rptr_q + AW'(1);
                    if (ovwr_q != '1) ovwr_d = ovwr_q + CNT_BITS'(1);
                end else begin
                    count_d = count_q + (AW+1)'(1);
                end
            end
            if (STORE_I) begin
                if (storePerm) begin
                    dmem_d  = DATA_I;
                    pendW_d = 1'b1;
                end else if (drop_q != '1) begin
                    drop_d = drop_q + CNT_BITS'(1);
                end
            end
            if (rc) begin
                data_d  = DMEM_I;
                grant_d = 1'b1;
                rptr_d  = rptr_q + AW'(1);
                count_d = count_q - (AW+1)'(1);
                pendR_d = 1'b0;
            end
            if (LOAD_REQUEST_I) pendR_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (TRG_EVENT_I) begin
                        eventAddr_d = wptr_q;
                        hist_d      = AW'(histProd >> DELAY_BITS);
                        state_d     = COUNTING;
                    end
                end
                COUNTING: begin
                    if (wc) begin
                        if (hist_q != '0) hist_d = hist_q - AW'(1);
                        else              state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            eventAddr_q <= '0;
            hist_q      <= '0;
            count_q     <= '0;
            mode_q      <= MODE_I;
            pendW_q     <= 1'b0;
            pendR_q     <= 1'b0;
            grant_q     <= 1'b0;
            dmem_q      <= '0;
            data_q      <= '0;
            drop_q      <= '0;
            ovwr_q      <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            eventAddr_q <= eventAddr_d;
            hist_q      <= hist_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            pendW_q     <= pendW_d;
            pendR_q     <= pendR_d;
            grant_q     <= grant_d;
            dmem_q      <= dmem_d;
            data_q      <= data_d;
            drop_q      <= drop_d;
            ovwr_q      <= ovwr_d;
        end
    end

    assign WRITE_O       = wc;
    assign WRITE_PTR_O   = wptr_q;
    assign READ_PTR_O    = rptr_q;
    assign DMEM_O        = dmem_q;
    assign STORE_PERM_O  = storePerm;
    assign LOAD_GRANT_O  = grant_q;
    assign DATA_O        = data_q;
    assign TRG_DELAYED_O = (state_q == DONE);
    assign EVENT_ADDR_O  = eventAddr_q;
    assign FILL_O        = count_q;
    assign DROP_CNT_O    = drop_q;
    assign OVWR_CNT_O    = ovwr_q;

endmodule

// File: tb/tb_trace_logger_mc.sv
// Directed bench for trace_logger_mc with a behavioural trace memory and a queue of
// expected load data that is consumed whenever the logger issues a grant.
module tb_trace_logger_mc;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DB    = 3;
    localparam int CB    = 4;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rstN, modeI, armI, rwTurn, writeAllow, readAllow;
    logic [DB-1:0]    delayI;
    logic             writeO, storeI, storePerm, loadReq, loadGrant, trgEvent, trgDelayed;
    logic [AW-1:0]    writePtr, readPtr, eventAddr;
    logic [WIDTH-1:0] dmemO, dmemI, dataI, dataO;
    logic [AW:0]      fill;
    logic [CB-1:0]    dropCnt, ovwrCnt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] expQ [$];
    int               compared = 0;
    int               mismatched = 0;
    logic             lastWrite, lastPerm;

    always #5 clk = ~clk;

    // Single-port trace memory: synchronous write, read data follows the read pointer.
    always @(posedge clk) if (writeO) mem[writePtr] <= dmemO;
    assign dmemI = mem[readPtr];

    trace_logger_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_BITS(DB), .CNT_BITS(CB)) dut (
        .CLK_I(clk), .RST_NI(rstN), .MODE_I(modeI), .DELAY_I(delayI), .ARM_I(armI),
        .RW_TURN_I(rwTurn), .WRITE_ALLOW_I(writeAllow), .READ_ALLOW_I(readAllow),
        .WRITE_O(writeO), .WRITE_PTR_O(writePtr), .READ_PTR_O(readPtr), .DMEM_O(dmemO),
        .DMEM_I(dmemI), .STORE_I(storeI), .DATA_I(dataI), .STORE_PERM_O(storePerm),
        .LOAD_REQUEST_I(loadReq), .LOAD_GRANT_O(loadGrant), .DATA_O(dataO),
        .TRG_EVENT_I(trgEvent), .TRG_DELAYED_O(trgDelayed), .EVENT_ADDR_O(eventAddr),
        .FILL_O(fill), .DROP_CNT_O(dropCnt), .OVWR_CNT_O(ovwrCnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock step; every grant the logger issues must match the oldest expected word.
    task automatic applyStimulus(input logic st, input logic [WIDTH-1:0] d, input logic rw,
                                 input logic wa, input logic ra, input logic ld,
                                 input logic trg, input logic arm);
        storeI = st; dataI = d; rwTurn = rw; writeAllow = wa; readAllow = ra;
        loadReq = ld; trgEvent = trg; armI = arm;
        #1;
        lastWrite = writeO;
        lastPerm  = storePerm;
        @(posedge clk);
        #1;
        if (loadGrant) begin
            checkOutput("grant expected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) checkOutput("grant data", 64'(dataO), 64'(expQ.pop_front()));
        end
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic readWord(input logic expectGrant, input logic [WIDTH-1:0] d);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (expectGrant) expQ.push_back(d);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic arm(input logic m);
        modeI = m;
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rstN = 1'b0; modeI = 1'b1; delayI = '0; armI = 1'b0; rwTurn = 1'b0;
        writeAllow = 1'b0; readAllow = 1'b0; storeI = 1'b0; dataI = '0;
        loadReq = 1'b0; trgEvent = 1'b0;
        #2;
        checkOutput("reset WRITE_O", 64'(writeO), 64'd0);
        checkOutput("reset STORE_PERM_O", 64'(storePerm), 64'd1);
        checkOutput("reset FILL_O", 64'(fill), 64'd0);
        checkOutput("reset LOAD_GRANT_O", 64'(loadGrant), 64'd0);
        checkOutput("reset TRG_DELAYED_O", 64'(trgDelayed), 64'd0);
        #10 rstN = 1'b1;

        // Streaming: fill to capacity, then back-pressure and a drop.
        for (int i = 0; i < DEPTH; i++) pushWord(16'(16'h0100 + i));
        checkOutput("stream fill full", 64'(fill), 64'd8);
        checkOutput("stream wptr wrap", 64'(writePtr), 64'd0);
        pushWord(16'h01FF);
        checkOutput("stream write blocked", 64'(lastWrite), 64'd0);
        applyStimulus(1'b1, 16'h02FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stream perm low", 64'(lastPerm), 64'd0);
        checkOutput("stream drop count", 64'(dropCnt), 64'd1);
        readWord(1'b1, 16'h0100);
        checkOutput("stream fill after read", 64'(fill), 64'd7);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stream pending commit", 64'(lastWrite), 64'd1);
        checkOutput("stream wptr after commit", 64'(writePtr), 64'd1);

        arm(1'b1);
        checkOutput("arm fill", 64'(fill), 64'd0);
        checkOutput("arm drop cleared", 64'(dropCnt), 64'd0);
        checkOutput("arm wptr", 64'(writePtr), 64'd0);

        // Streaming FIFO order and empty-buffer load.
        pushWord(16'h000A); pushWord(16'h000B); pushWord(16'h000C);
        checkOutput("fifo fill 3", 64'(fill), 64'd3);
        readWord(1'b1, 16'h000A); readWord(1'b1, 16'h000B); readWord(1'b1, 16'h000C);
        checkOutput("fifo drained", 64'(fill), 64'd0);
        readWord(1'b0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Trace mode without trigger: circular overwrite and saturating statistic.
        arm(1'b0);
        for (int i = 0; i < 10; i++) pushWord(16'(16'h0300 + i));
        checkOutput("trace fill", 64'(fill), 64'd8);
        checkOutput("trace overwrites", 64'(ovwrCnt), 64'd2);
        checkOutput("trace wptr", 64'(writePtr), 64'd2);
        checkOutput("trace rptr", 64'(readPtr), 64'd2);
        for (int i = 0; i < 20; i++) pushWord(16'(16'h0310 + i));
        checkOutput("trace overwrite saturation", 64'(ovwrCnt), 64'd15);
        readWord(1'b0, '0);

        // Trace mode with delayed trigger at write pointer 5.
        arm(1'b0);
        delayI = 3'd3;
        for (int i = 0; i < 5; i++) pushWord(16'(16'h0400 + i));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("trigger event addr", 64'(eventAddr), 64'd5);
        for (int i = 0; i < 3; i++) pushWord(16'(16'h0410 + i));
        checkOutput("trigger quota pending", 64'(trgDelayed), 64'd0);
        pushWord(16'h0413);
        checkOutput("trigger delayed set", 64'(trgDelayed), 64'd1);
        checkOutput("trigger overwrites", 64'(ovwrCnt), 64'd1);
        pushWord(16'h0420);
        checkOutput("trigger writes frozen", 64'(lastWrite), 64'd0);
        checkOutput("trigger wptr frozen", 64'(writePtr), 64'd1);
        readWord(1'b1, 16'h0401);
        readWord(1'b1, 16'h0402);
        checkOutput("trigger fill after reads", 64'(fill), 64'd6);

        // Re-arm into streaming mode after the freeze.
        arm(1'b1);
        checkOutput("rearm delayed", 64'(trgDelayed), 64'd0);
        checkOutput("rearm overwrites", 64'(ovwrCnt), 64'd0);
        checkOutput("rearm event addr", 64'(eventAddr), 64'd0);
        checkOutput("rearm rptr", 64'(readPtr), 64'd0);
        pushWord(16'h0500);
        readWord(1'b1, 16'h0500);

        // Reset with a load pending: outputs clear at once and the load is forgotten.
        pushWord(16'h0600);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async reset DATA_O", 64'(dataO), 64'd0);
        checkOutput("async reset FILL_O", 64'(fill), 64'd0);
        checkOutput("async reset wptr", 64'(writePtr), 64'd0);
        checkOutput("async reset perm", 64'(storePerm), 64'd1);
        @(posedge clk);
        #1 rstN = 1'b1;
        pushWord(16'h0601);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post reset fill", 64'(fill), 64'd1);
        checkOutput("grants outstanding", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
